// File: rtl/bufif_bus_arbiter.sv
// Purpose: round-robin owner selection for one shared tri-state net driven through per-requester bufif1 gates.
// Latency: request sampled in IDLE -> gnt after 1 edge, drv_en after 2 edges; release -> next gnt after TURN_CYCLES+1 edges.
// Backpressure: requests are level-held; non-owners wait until owner drops req or hits MAX_HOLD with others waiting.
module bufif_bus_arbiter #(
    parameter int N           = 4,
    parameter int IDW         = 2,
    parameter int MAX_HOLD    = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   drv_en,
    output logic [IDW-1:0] owner,
    output logic           busy
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {IDLE, SETUP, GRANT, TURN} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   drv_en_q, drv_en_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [3:0]     turn_cnt_q, turn_cnt_d;
    logic           busy_q, busy_d;

    logic [IDW-1:0] sel;
    logic           sel_vld;
    logic           others_waiting;
    logic           rel;

    // Index arithmetic modulo N, so the search and the pointer advance wrap N-1 -> 0.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= N) s = s - N;
        return IDW'(s);
    endfunction

    // First requester at or after ptr, searching upward with wrap.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!sel_vld && req[wrap_add(ptr_q, i)]) begin
                sel     = wrap_add(ptr_q, i);
                sel_vld = 1'b1;
            end
        end
    end

    // Next-state and next-output computation for the grant sequencer.
    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        drv_en_d       = drv_en_q;
        owner_d        = owner_q;
        ptr_d          = ptr_q;
        hold_cnt_d     = hold_cnt_q;
        turn_cnt_d     = turn_cnt_q;
        rel            = 1'b0;
        // gnt_q is onehot(owner) whenever a release can be evaluated
        others_waiting = |(req & ~gnt_q);

        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    gnt_d      = '0;
                    gnt_d[sel] = 1'b1;
                    owner_d    = sel;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                // The gate is only opened if the owner still wants the net.
                if (req[owner_q]) begin
                    drv_en_d   = gnt_q;
                    hold_cnt_d = HW'(1);
                    state_d    = GRANT;
                end else begin
                    rel = 1'b1;
                end
            end
            GRANT: begin
                if (!req[owner_q] || (hold_cnt_q == HW'(MAX_HOLD) && others_waiting)) begin
                    rel = 1'b1;
                end else if (hold_cnt_q != HW'(MAX_HOLD)) begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            TURN: begin
                if (turn_cnt_q == 4'(TURN_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    turn_cnt_d = turn_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Release closes the gate at the same edge grant drops; the dead cycles follow.
        if (rel) begin
            gnt_d      = '0;
            drv_en_d   = '0;
            ptr_d      = wrap_add(owner_q, 1);
            turn_cnt_d = '0;
            state_d    = (TURN_CYCLES > 0) ? TURN : IDLE;
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            drv_en_q   <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            turn_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            drv_en_q   <= drv_en_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt    = gnt_q;
    assign drv_en = drv_en_q;
    assign owner  = owner_q;
    assign busy   = busy_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_drv_in_gnt: assert property (@(posedge clk) disable iff (rst) (drv_en_q & ~gnt_q) == '0);
    a_drv_only_grant: assert property (@(posedge clk) disable iff (rst)
        (state_q != GRANT) |-> (drv_en_q == '0));
    a_no_overlap: assert property (@(posedge clk) disable iff (rst)
        ($past(drv_en_q) == '0) || (drv_en_q == '0) || (drv_en_q == $past(drv_en_q)));

endmodule
